// File: rtl/player_motion.sv
// player_motion: per-frame sprite motion (walk, gravity, jump, wall/floor/ceiling clamping).
// Optional air jump enabled by defining PLAYER_MOTION_DOUBLE_JUMP_EN.
module player_motion #(
    parameter int X_W      = 10,
    parameter int V_W      = 8,
    parameter int SCREEN_W = 640,
    parameter int GROUND_Y = 480,
    parameter int PW       = 20,
    parameter int PH       = 40,
    parameter int SPEED    = 2,
    parameter int GRAV     = 1,
    parameter int MAX_FALL = 8,
    parameter int JUMP_V   = 10,
    parameter int X_INIT   = 128,
    parameter int Y_INIT   = 400
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  v_sync,
    input  logic [3:0]            pb,
    output logic [X_W-1:0]        pos_x,
    output logic [X_W-1:0]        pos_y,
    output logic signed [V_W-1:0] vel_y,
    output logic                  grounded,
    output logic                  facing,
    output logic                  upd_done
);
    // Interface: v_sync and pb are asynchronous levels; no back-pressure exists. Each synchronised
    // v_sync rise seen in IDLE yields one update, and upd_done strobes for one cycle once outputs change.
    typedef enum logic [1:0] {IDLE, VEL, POS, CLAMP} state_t;

    localparam int SW = X_W + 2;
    localparam logic signed [SW-1:0]  X_MAX   = SW'(SCREEN_W - PW);
    localparam logic signed [SW-1:0]  Y_FLOOR = SW'(GROUND_Y - PH);
    localparam logic signed [SW-1:0]  STEP    = SW'(SPEED);
    localparam logic signed [V_W+1:0] V_MAX   = (V_W+2)'(MAX_FALL);
    localparam logic signed [V_W+1:0] G_ONE   = (V_W+2)'(GRAV);
    localparam logic signed [V_W+1:0] G_TWO   = (V_W+2)'(2 * GRAV);
    localparam logic signed [V_W-1:0] V_JUMP  = V_W'(-JUMP_V);

    state_t                state_q, state_d;
    logic [3:0]            pb_s1_q, pb_s2_q;
    logic                  vs_s1_q, vs_s2_q, vs_prev_q;
    logic [3:0]            btn_q, btn_d;
    logic                  jump_prev_q, jump_prev_d;
    logic signed [V_W-1:0] vel_w_q, vel_w_d;
    logic signed [SW-1:0]  nx_q, nx_d, ny_q, ny_d;
    logic [X_W-1:0]        pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    logic signed [V_W-1:0] vel_y_q, vel_y_d;
    logic                  grounded_q, grounded_d;
    logic                  facing_q, facing_d;
    logic                  upd_done_q, upd_done_d;
    logic                  frame_evt, jump_edge, right_only, left_only;
    logic signed [SW-1:0]  dx;
    logic signed [V_W+1:0] vel_sum;
`ifdef PLAYER_MOTION_DOUBLE_JUMP_EN
    logic                  token_q, token_d;
`endif

    always_comb begin
        state_d     = state_q;
        btn_d       = btn_q;
        jump_prev_d = jump_prev_q;
        vel_w_d     = vel_w_q;
        nx_d        = nx_q;
        ny_d        = ny_q;
        pos_x_d     = pos_x_q;
        pos_y_d     = pos_y_q;
        vel_y_d     = vel_y_q;
        grounded_d  = grounded_q;
        facing_d    = facing_q;
        upd_done_d  = 1'b0;
`ifdef PLAYER_MOTION_DOUBLE_JUMP_EN
        token_d     = token_q;
`endif
        frame_evt  = vs_s2_q & ~vs_prev_q;
        jump_edge  = btn_q[1] & ~jump_prev_q;
        right_only = btn_q[0] & ~btn_q[2];
        left_only  = btn_q[2] & ~btn_q[0];
        dx         = right_only ? STEP : (left_only ? -STEP : '0);
        vel_sum    = (V_W+2)'(vel_y_q) + (btn_q[3] ? G_TWO : G_ONE);

        case (state_q)
            IDLE: begin
                if (frame_evt) begin
                    btn_d       = pb_s2_q;
                    jump_prev_d = btn_q[1];
                    state_d     = VEL;
                end
            end
            VEL: begin
                state_d = POS;
                if (jump_edge && grounded_q) begin
                    vel_w_d = V_JUMP;
                end
`ifdef PLAYER_MOTION_DOUBLE_JUMP_EN
                else if (jump_edge && !grounded_q && token_q) begin
                    vel_w_d = V_JUMP;
                    token_d = 1'b0;
                end
`endif
                else if (!grounded_q) begin
                    vel_w_d = (vel_sum > V_MAX) ? V_MAX[V_W-1:0] : vel_sum[V_W-1:0];
                end else begin
                    vel_w_d = '0;
                end
            end
            POS: begin
                state_d = CLAMP;
                nx_d    = $signed({2'b00, pos_x_q}) + dx;
                ny_d    = $signed({2'b00, pos_y_q}) + SW'(vel_w_q);
            end
            CLAMP: begin
                state_d    = IDLE;
                upd_done_d = 1'b1;
                if (nx_q[SW-1])        pos_x_d = '0;
                else if (nx_q > X_MAX) pos_x_d = X_MAX[X_W-1:0];
                else                   pos_x_d = nx_q[X_W-1:0];
                if (ny_q >= Y_FLOOR) begin
                    pos_y_d    = Y_FLOOR[X_W-1:0];
                    vel_y_d    = '0;
                    grounded_d = 1'b1;
                end else if (ny_q[SW-1]) begin
                    pos_y_d    = '0;
                    vel_y_d    = '0;
                    grounded_d = 1'b0;
                end else begin
                    pos_y_d    = ny_q[X_W-1:0];
                    vel_y_d    = vel_w_q;
                    grounded_d = 1'b0;
                end
                if (right_only)     facing_d = 1'b1;
                else if (left_only) facing_d = 1'b0;
`ifdef PLAYER_MOTION_DOUBLE_JUMP_EN
                if (grounded_d && !grounded_q) token_d = 1'b1;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pb_s1_q     <= '0;
            pb_s2_q     <= '0;
            vs_s1_q     <= 1'b0;
            vs_s2_q     <= 1'b0;
            vs_prev_q   <= 1'b0;
            btn_q       <= '0;
            jump_prev_q <= 1'b0;
            vel_w_q     <= '0;
            nx_q        <= '0;
            ny_q        <= '0;
            pos_x_q     <= X_W'(X_INIT);
            pos_y_q     <= X_W'(Y_INIT);
            vel_y_q     <= '0;
            grounded_q  <= 1'b0;
            facing_q    <= 1'b1;
            upd_done_q  <= 1'b0;
`ifdef PLAYER_MOTION_DOUBLE_JUMP_EN
            token_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            pb_s1_q     <= pb;
            pb_s2_q     <= pb_s1_q;
            vs_s1_q     <= v_sync;
            vs_s2_q     <= vs_s1_q;
            vs_prev_q   <= vs_s2_q;
            btn_q       <= btn_d;
            jump_prev_q <= jump_prev_d;
            vel_w_q     <= vel_w_d;
            nx_q        <= nx_d;
            ny_q        <= ny_d;
            pos_x_q     <= pos_x_d;
            pos_y_q     <= pos_y_d;
            vel_y_q     <= vel_y_d;
            grounded_q  <= grounded_d;
            facing_q    <= facing_d;
            upd_done_q  <= upd_done_d;
`ifdef PLAYER_MOTION_DOUBLE_JUMP_EN
            token_q     <= token_d;
`endif
        end
    end

    assign pos_x    = pos_x_q;
    assign pos_y    = pos_y_q;
    assign vel_y    = vel_y_q;
    assign grounded = grounded_q;
    assign facing   = facing_q;
    assign upd_done = upd_done_q;
endmodule

// File: tb/tb_player_motion.sv
// tb_player_motion: directed + random frames against a frame-level arithmetic model of player_motion.
// Honours PLAYER_MOTION_DOUBLE_JUMP_EN when the same define is given to the bench.
module tb_player_motion;
    localparam int X_W      = 10;
    localparam int V_W      = 8;
    localparam int SCREEN_W = 640;
    localparam int GROUND_Y = 480;
    localparam int PW       = 20;
    localparam int PH       = 40;
    localparam int SPEED    = 2;
    localparam int GRAV     = 1;
    localparam int MAX_FALL = 8;
    localparam int JUMP_V   = 10;
    localparam int X_INIT   = 128;
    localparam int Y_INIT   = 400;
    localparam int X_MAX    = SCREEN_W - PW;
    localparam int Y_FLOOR  = GROUND_Y - PH;
    localparam int FRAME_LAT = 6;  // raw v_sync rise to upd_done: 2 sync + edge detect + VEL/POS/CLAMP
`ifdef PLAYER_MOTION_DOUBLE_JUMP_EN
    localparam bit DJ = 1'b1;
`else
    localparam bit DJ = 1'b0;
`endif

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  rst_n;
    logic                  v_sync;
    logic [3:0]            pb;
    logic [X_W-1:0]        pos_x, pos_y;
    logic signed [V_W-1:0] vel_y;
    logic                  grounded, facing, upd_done;

    player_motion dut (
        .clk(clk), .rst_n(rst_n), .v_sync(v_sync), .pb(pb),
        .pos_x(pos_x), .pos_y(pos_y), .vel_y(vel_y),
        .grounded(grounded), .facing(facing), .upd_done(upd_done)
    );

    int vectors = 0;
    int miscompares = 0;

    // reference model state, one value per game-level quantity
    int m_x, m_y, m_v, m_g, m_f, m_tok, m_prevj;
    logic [29:0] exp_q[$];

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_x = X_INIT; m_y = Y_INIT; m_v = 0; m_g = 0; m_f = 1; m_tok = 0; m_prevj = 0;
        exp_q.delete();
    endtask

    // One game frame: walk, then velocity rules, then move and clamp to the playfield.
    task automatic model_frame(input logic [3:0] b);
        bit right, left, jump, down, jedge;
        int ny;
        right = b[0]; jump = b[1]; left = b[2]; down = b[3];
        jedge = jump && !m_prevj;
        m_prevj = jump;
        if (jedge && m_g) m_v = -JUMP_V;
        else if (DJ && jedge && !m_g && m_tok) begin m_v = -JUMP_V; m_tok = 0; end
        else if (!m_g) m_v = (m_v + GRAV + (down ? GRAV : 0) > MAX_FALL) ? MAX_FALL : m_v + GRAV + (down ? GRAV : 0);
        else m_v = 0;
        if (right && !left) begin m_x = m_x + SPEED; m_f = 1; end
        else if (left && !right) begin m_x = m_x - SPEED; m_f = 0; end
        if (m_x < 0) m_x = 0;
        if (m_x > X_MAX) m_x = X_MAX;
        ny = m_y + m_v;
        if (ny >= Y_FLOOR) begin
            if (!m_g) m_tok = 1;
            m_y = Y_FLOOR; m_v = 0; m_g = 1;
        end else if (ny < 0) begin
            m_y = 0; m_v = 0; m_g = 0;
        end else begin
            m_y = ny; m_g = 0;
        end
        exp_q.push_back({10'(m_x), 10'(m_y), 8'(m_v), 1'(m_g), 1'(m_f)});
    endtask

    task automatic check_scoreboard(input string tag);
        logic [29:0] e;
        e = exp_q.pop_front();
        check({tag, "_x"}, pos_x, e[29:20]);
        check({tag, "_y"}, pos_y, e[19:10]);
        check({tag, "_vel"}, vel_y, $signed(e[9:2]));
        check({tag, "_grounded"}, grounded, e[1]);
        check({tag, "_facing"}, facing, e[0]);
    endtask

    // driver: one full frame with buttons b held, checked on its upd_done
    task automatic do_frame(input logic [3:0] b, input string tag);
        int lat;
        @(negedge clk);
        pb = b;
        v_sync = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (upd_done !== 1'b1 && lat < 20);
        check({tag, "_latency"}, lat, FRAME_LAT);
        model_frame(b);
        check_scoreboard(tag);
        @(negedge clk);
        check({tag, "_done_width"}, upd_done, 1'b0);
        v_sync = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, peak, prev_v, pulses;
        logic [3:0] rb;

        rst_n = 1'b0; v_sync = 1'b0; pb = 4'b0000;
        repeat (4) @(negedge clk);
        model_reset();
        check("rst_x", pos_x, X_INIT);
        check("rst_y", pos_y, Y_INIT);
        check("rst_vel", vel_y, 0);
        check("rst_grounded", grounded, 1'b0);
        check("rst_facing", facing, 1'b1);
        check("rst_done", upd_done, 1'b0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // free fall from spawn
        do_frame(4'b0000, "fall1"); check("fall1_vel_c", vel_y, 1); check("fall1_y_c", pos_y, 401);
        do_frame(4'b0000, "fall2"); check("fall2_vel_c", vel_y, 2); check("fall2_y_c", pos_y, 403);
        do_frame(4'b0000, "fall3"); check("fall3_vel_c", vel_y, 3); check("fall3_y_c", pos_y, 406);
        peak = 3; n = 0;
        while (m_g == 0 && n < 20) begin
            do_frame(4'b0000, $sformatf("fall_more%0d", n));
            if (m_g == 0 && m_v > peak) peak = m_v;
            n++;
        end
        check("fall_peak_vel", peak, MAX_FALL);
        check("land_y", pos_y, Y_FLOOR);
        check("land_grounded", grounded, 1'b1);
        check("land_vel", vel_y, 0);

        // walk into the left wall, then right, then both
        n = 0;
        while (m_x > 0 && n < 100) begin do_frame(4'b0100, "walk_left"); n++; end
        for (int i = 0; i < 3; i++) begin
            do_frame(4'b0100, $sformatf("left_wall%0d", i));
            check($sformatf("left_wall%0d_x_c", i), pos_x, 0);
            check($sformatf("left_wall%0d_face_c", i), facing, 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            do_frame(4'b0001, $sformatf("right%0d", i));
            check($sformatf("right%0d_x_c", i), pos_x, 2 * (i + 1));
            check($sformatf("right%0d_face_c", i), facing, 1'b1);
        end
        do_frame(4'b0101, "both");
        check("both_x_c", pos_x, 6);

        // held jump fires once; down doubles gravity
        do_frame(4'b0010, "jump1"); check("jump1_vel_c", vel_y, -10); check("jump1_y_c", pos_y, 430);
        do_frame(4'b0010, "jump2"); check("jump2_vel_c", vel_y, -9); check("jump2_y_c", pos_y, 421);
        n = 0;
        while (m_g == 0 && n < 30) begin
            prev_v = m_v;
            do_frame(4'b1000, $sformatf("down%0d", n));
            if (m_g == 0) check($sformatf("down%0d_vel_c", n), vel_y, (prev_v + 2 > MAX_FALL) ? MAX_FALL : prev_v + 2);
            n++;
        end

        // air jump: one allowed with the token, none without
        do_frame(4'b0000, "dj_rest");
        do_frame(4'b0010, "dj_ground_jump");
        do_frame(4'b0000, "dj_release1");
        prev_v = m_v;
        do_frame(4'b0010, "dj_air_press");
        check("dj_air_press_vel_c", vel_y, DJ ? -JUMP_V : prev_v + GRAV);
        do_frame(4'b0000, "dj_release2");
        prev_v = m_v;
        do_frame(4'b0010, "dj_third_press");
        check("dj_third_press_vel_c", vel_y, prev_v + GRAV);
        n = 0;
        while (m_g == 0 && n < 30) begin do_frame(4'b0000, "dj_fall"); n++; end

        // right wall
        n = 0;
        while (m_x < X_MAX && n < 400) begin do_frame(4'b0001, "walk_right"); n++; end
        do_frame(4'b0001, "right_wall");
        check("right_wall_x_c", pos_x, X_MAX);

        // random button frames
        for (int i = 0; i < 40; i++) begin
            rb = 4'($urandom_range(0, 15));
            do_frame(rb, $sformatf("rand%0d", i));
        end

        // second v_sync edge arriving during POS is ignored
        pb = 4'b0000;
        @(negedge clk); v_sync = 1'b1;
        @(negedge clk); v_sync = 1'b0;
        @(negedge clk); v_sync = 1'b1;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (upd_done === 1'b1) pulses++;
        end
        check("ignore_pulses", pulses, 1);
        model_frame(4'b0000);
        check_scoreboard("ignore");
        v_sync = 1'b0;
        repeat (4) @(negedge clk);

        // reset landing in POS aborts the update
        @(negedge clk); v_sync = 1'b1; pb = 4'b0001;
        repeat (4) @(negedge clk);
        rst_n = 1'b0; v_sync = 1'b0;
        @(negedge clk);
        model_reset();
        check("midrst_x", pos_x, X_INIT);
        check("midrst_y", pos_y, Y_INIT);
        check("midrst_vel", vel_y, 0);
        check("midrst_done", upd_done, 1'b0);
        rst_n = 1'b1;
        pulses = 0;
        repeat (10) begin
            @(negedge clk);
            if (upd_done === 1'b1) pulses++;
        end
        check("midrst_no_done", pulses, 0);
        check("midrst_hold_x", pos_x, X_INIT);

        for (int i = 0; i < 8; i++) begin
            rb = 4'($urandom_range(0, 15));
            do_frame(rb, $sformatf("post_rst%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/player_motion.md
PLAYER_MOTION -- requirements
Module: player_motion

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning): X_W 10 position width; V_W 8 signed vertical velocity width; SCREEN_W 640 playfield width; GROUND_Y 480 floor line; PW 20 sprite width; PH 40 sprite height; SPEED 2 horizontal step per frame; GRAV 1 gravity per frame; MAX_FALL 8 terminal velocity; JUMP_V 10 jump impulse; X_INIT 128 reset x; Y_INIT 400 reset y.
REQ-002 The block SHALL have these ports: clk in 1 system clock; rst_n in 1 synchronous active-low reset; v_sync in 1 raw vertical sync; pb in 4 buttons {down,left,jump,right} = pb[3:0]; pos_x out X_W sprite left edge; pos_y out X_W sprite top edge; vel_y out V_W signed velocity; grounded out 1 on floor; facing out 1 (1 = right); upd_done out 1 one-cycle frame-update pulse.
REQ-003 Reset SHALL be synchronous and active-low on rst_n, with a single clock clk.

Function
REQ-004 pb and v_sync SHALL each pass through a 2-flop synchroniser before use.
REQ-005 A frame event SHALL be a synchronised v_sync 0->1 transition, detected against a registered previous value.
REQ-006 FSM states SHALL be IDLE, VEL, POS, CLAMP; frame event in IDLE -> VEL -> POS -> CLAMP -> IDLE, one cycle each.
REQ-007 Frame events occurring outside IDLE SHALL be ignored.
REQ-008 In IDLE on a frame event, the synchronised buttons SHALL be latched; jump_edge = jump latched now AND not latched at previous frame.
REQ-009 dx SHALL be +SPEED for right only, -SPEED for left only, and 0 for both or neither.
REQ-010 facing SHALL become 1 on right-only and 0 on left-only, and SHALL otherwise hold.
REQ-011 VEL state: if jump_edge AND grounded, vel_y = -JUMP_V and grounded cleared.
REQ-012 VEL state: otherwise, if not grounded, vel_y = min(vel_y + GRAV + (down ? GRAV : 0), MAX_FALL).
REQ-013 VEL state: otherwise, vel_y = 0.
REQ-014 POS state: next x/y SHALL be computed in signed X_W+2 arithmetic as pos_x + dx and pos_y + vel_y (sign-extended); no wrap-around is permitted.
REQ-015 CLAMP state: x SHALL be clamped to [0, SCREEN_W-PW].
REQ-016 CLAMP state: if y >= GROUND_Y-PH, pos_y = GROUND_Y-PH, vel_y = 0, grounded = 1.
REQ-017 CLAMP state: if y < 0, pos_y = 0 and vel_y = 0 (ceiling).
REQ-018 CLAMP state: in all other cases pos_y = y and grounded = 0.
REQ-019 pos_x, pos_y, vel_y and grounded SHALL update only in CLAMP; upd_done SHALL be high for exactly that cycle.
REQ-020 Latency from the synchronised edge cycle to the output update SHALL be 3 clocks.
REQ-021 Outputs SHALL be registered and hold between updates.

Reset
REQ-022 While rst_n = 0 at a clk edge, the block SHALL load: state IDLE, pos_x = X_INIT, pos_y = Y_INIT, vel_y = 0, grounded = 0, facing = 1, upd_done = 0, synchronisers and latched buttons 0, air-jump token cleared.
REQ-023 A reset asserted mid-update SHALL abort the update: no upd_done is produced and no partial position is committed.

Configuration
REQ-024 Macro PLAYER_MOTION_DOUBLE_JUMP_EN defined: one air-jump token SHALL be set on landing (grounded 0->1); jump_edge while airborne with the token held SHALL set vel_y = -JUMP_V and consume the token.
REQ-025 Macro PLAYER_MOTION_DOUBLE_JUMP_EN undefined: the token logic SHALL be absent and airborne jump_edge SHALL be ignored.

Verification (default parameters)
REQ-026 Reset then 3 frames with no buttons -> vel_y 1, 2, 3; pos_y 401, 403, 406; grounded 0.
REQ-027 Continued falling -> vel_y saturates at 8; pos_y clamps to 440, grounded = 1, vel_y = 0.
REQ-028 Grounded at x=0: left for 3 frames -> pos_x stays 0, facing 0; then right for 3 frames -> pos_x 2, 4, 6, facing 1; left+right -> pos_x unchanged.
REQ-029 Grounded at y=440: jump held for 2 frames -> frame1 vel_y -10, pos_y 430; frame2 vel_y -9, pos_y 421 (no retrigger); down held while falling -> velocity increments by 2.
REQ-030 A second v_sync edge injected in POS is ignored (one upd_done only); rst_n low during POS -> next cycle pos = (128, 400), upd_done stays 0.
REQ-031 With PLAYER_MOTION_DOUBLE_JUMP_EN defined, a mid-air jump press sets vel_y = -10 once and a third press is ignored until landing; with the macro undefined, a mid-air press leaves vel_y unchanged.
